// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: turns one CPU memory request into a word-aligned bus
// access with byte lanes, extends load data, and reports type/alignment/timeout errors.
module lsu_mem_initiator #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             CPU_clk,
    input  logic             CPU_rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_store,
    input  logic [2:0]       MemDataType,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [3:0]       mem_be,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_rdata,
    output logic [1:0]       resp_err
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t           state, next_state;
    logic             store_q;
    logic [2:0]       type_q;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rdata_q;
    logic [1:0]       err_q;

    logic             illegal;
    logic             misaligned;
    logic [1:0]       req_err;
    logic [1:0]       off;
    logic [WIDTH-1:0] lane;
    logic [WIDTH-1:0] load_data;
    logic             timeout_hit;

    // Request checks only feed registers; mem_* never sees req_* combinationally.
    always_comb begin
        illegal    = req_store ? (MemDataType > 3'b010)
                               : (MemDataType == 3'b011 || MemDataType[2:1] == 2'b11);
        misaligned = (MemDataType[1:0] == 2'b01 && req_addr[0])
                  || (MemDataType == 3'b010 && req_addr[1:0] != 2'b00);
        if (illegal)
            req_err = 2'b10;
        else if (misaligned)
            req_err = 2'b01;
        else
            req_err = 2'b00;
    end

    always_comb begin
        off  = addr_q[1:0];
        lane = mem_rdata >> {off, 3'b000};
        case (type_q)
            3'b000:  load_data = {{(WIDTH-8){lane[7]}}, lane[7:0]};
            3'b001:  load_data = {{(WIDTH-16){lane[15]}}, lane[15:0]};
            3'b100:  load_data = {{(WIDTH-8){1'b0}}, lane[7:0]};
            3'b101:  load_data = {{(WIDTH-16){1'b0}}, lane[15:0]};
            default: load_data = lane;
        endcase
    end

    assign timeout_hit = (cnt == CNT_LAST);

    always_ff @(posedge CPU_clk or posedge CPU_rst) begin
        if (CPU_rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (req_valid) next_state = (req_err != 2'b00) ? RESP : BUS;
            BUS:  if (mem_ack || timeout_hit) next_state = RESP;
            RESP: if (resp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CPU_clk or posedge CPU_rst) begin
        if (CPU_rst) begin
            store_q <= 1'b0;
            type_q  <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        store_q <= req_store;
                        type_q  <= MemDataType;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt     <= '0;
                        rdata_q <= '0;
                        err_q   <= req_err;
                    end
                end
                BUS: begin
                    // An ack in the last allowed cycle beats the timeout.
                    if (mem_ack) begin
                        rdata_q <= store_q ? '0 : load_data;
                        err_q   <= 2'b00;
                    end else if (timeout_hit) begin
                        rdata_q <= '0;
                        err_q   <= 2'b11;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready  = (state == IDLE);
        mem_req    = (state == BUS);
        mem_we     = mem_req && store_q;
        mem_addr   = mem_req ? {addr_q[WIDTH-1:2], 2'b00} : '0;
        mem_wdata  = mem_we ? (wdata_q << {off, 3'b000}) : '0;
        mem_be     = 4'b0000;
        if (mem_req) begin
            case (type_q[1:0])
                2'b00:   mem_be = 4'b0001 << off;
                2'b01:   mem_be = 4'b0011 << off;
                default: mem_be = 4'b1111;
            endcase
        end
        resp_valid = (state == RESP);
        resp_rdata = rdata_q;
        resp_err   = err_q;
    end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Scoreboard bench for lsu_mem_initiator: directed requests push expected
// responses; a monitor pops and compares on every response handshake.
module tb_lsu_mem_initiator;

    localparam int TIMEOUT = 16;

    logic        CPU_clk = 1'b0;
    logic        CPU_rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  MemDataType = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    lsu_mem_initiator #(.WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
        .CPU_clk(CPU_clk), .CPU_rst(CPU_rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .MemDataType(MemDataType), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 CPU_clk = ~CPU_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every response handshake must match the oldest expectation.
    always @(negedge CPU_clk) begin
        if (!CPU_rst && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_resp: got resp_err %0d rdata 0x%08h expected no response",
                         resp_err, resp_rdata);
            end else begin
                mon_e = sb.pop_front();
                chk("resp_rdata", resp_rdata, mon_e.rdata);
                chk("resp_err", {30'b0, resp_err}, {30'b0, mon_e.err});
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge CPU_clk);
        while (!req_ready && n < 100) begin
            @(negedge CPU_clk);
            n++;
        end
        chk("req_ready_wait", {31'b0, req_ready}, 32'd1);
    endtask

    // ack_cyc: BUS cycle (1-based) carrying mem_ack, 0 = never; hold: cycles resp_ready stays low.
    task automatic issue(input logic st, input logic [2:0] typ, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] eerr,
                         input logic [31:0] erdata, input logic [3:0] ebe,
                         input logic [31:0] ewdata, input int ack_cyc,
                         input logic [31:0] rword, input int hold);
        exp_t e;
        bit done;
        wait_ready();
        req_valid   = 1'b1;
        req_store   = st;
        MemDataType = typ;
        req_addr    = addr;
        req_wdata   = wdata;
        e.rdata = erdata;
        e.err   = eerr;
        sb.push_back(e);
        if (hold > 0) resp_ready = 1'b0;
        @(posedge CPU_clk);
        #1 req_valid = 1'b0;
        if (eerr == 2'b01 || eerr == 2'b10) begin
            @(negedge CPU_clk);
            chk("err_no_mem_req", {31'b0, mem_req}, 32'd0);
            chk("err_resp_latency", {31'b0, resp_valid}, 32'd1);
        end else begin
            done = 1'b0;
            for (int k = 1; k <= TIMEOUT && !done; k++) begin
                @(negedge CPU_clk);
                chk("mem_req", {31'b0, mem_req}, 32'd1);
                chk("mem_we", {31'b0, mem_we}, {31'b0, st});
                chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
                chk("mem_be", {28'b0, mem_be}, {28'b0, ebe});
                chk("mem_wdata", mem_wdata, ewdata);
                if (k == ack_cyc) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rword;
                    done      = 1'b1;
                end
                @(posedge CPU_clk);
                #1 mem_ack = 1'b0;
            end
            @(negedge CPU_clk);
            chk("mem_req_drop", {31'b0, mem_req}, 32'd0);
            chk("resp_latency", {31'b0, resp_valid}, 32'd1);
        end
        if (hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                if (h > 0) @(negedge CPU_clk);
                chk("hold_resp_valid", {31'b0, resp_valid}, 32'd1);
                chk("hold_resp_rdata", resp_rdata, erdata);
                chk("hold_resp_err", {30'b0, resp_err}, {30'b0, eerr});
                chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
                chk("hold_mem_req", {31'b0, mem_req}, 32'd0);
                req_valid   = 1'b1;
                req_store   = 1'b1;
                MemDataType = 3'b010;
                req_addr    = 32'h0000_0100;
                mem_ack     = 1'b1;
                mem_rdata   = 32'hFFFF_FFFF;
                @(posedge CPU_clk);
                #1;
            end
            req_valid  = 1'b0;
            mem_ack    = 1'b0;
            resp_ready = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge CPU_clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        CPU_rst = 1'b0;

        //     st    typ     addr          wdata         err    rdata         be       wdata_exp     ack rword         hold
        issue(1'b1, 3'b000, 32'h0000_0013, 32'h0000_00A5, 2'b00, 32'h0,        4'b1000, 32'hA500_0000, 1, 32'h0,        0);
        issue(1'b0, 3'b001, 32'h0000_0022, 32'hDEAD_BEEF, 2'b00, 32'hFFFF_8001, 4'b1100, 32'h0,        2, 32'h8001_1234, 0);
        issue(1'b0, 3'b101, 32'h0000_0022, 32'h0,         2'b00, 32'h0000_8001, 4'b1100, 32'h0,        1, 32'h8001_1234, 0);
        issue(1'b0, 3'b100, 32'h0000_0021, 32'h0,         2'b00, 32'h0000_0012, 4'b0010, 32'h0,        3, 32'h8001_1234, 0);
        issue(1'b0, 3'b010, 32'h0000_0006, 32'h0,         2'b01, 32'h0,        4'b0000, 32'h0,        0, 32'h0,        0);
        issue(1'b0, 3'b101, 32'h0000_0023, 32'h0,         2'b01, 32'h0,        4'b0000, 32'h0,        0, 32'h0,        0);
        issue(1'b1, 3'b100, 32'h0000_0010, 32'h0000_0055, 2'b10, 32'h0,        4'b0000, 32'h0,        0, 32'h0,        0);
        issue(1'b0, 3'b011, 32'h0000_0001, 32'h0,         2'b10, 32'h0,        4'b0000, 32'h0,        0, 32'h0,        0);
        issue(1'b0, 3'b010, 32'h0000_0040, 32'h1111_1111, 2'b11, 32'h0,        4'b1111, 32'h0,        0, 32'h0,        0);
        issue(1'b0, 3'b010, 32'h0000_0044, 32'h1111_1111, 2'b00, 32'hCAFE_F00D, 4'b1111, 32'h0,       16, 32'hCAFE_F00D, 0);
        issue(1'b0, 3'b000, 32'h0000_0003, 32'h0,         2'b00, 32'hFFFF_FF80, 4'b1000, 32'h0,        1, 32'h80AA_BB11, 5);
        issue(1'b1, 3'b010, 32'h0000_0008, 32'h1234_5678, 2'b00, 32'h0,        4'b1111, 32'h1234_5678, 1, 32'h0,        0);
        issue(1'b1, 3'b001, 32'h0000_0002, 32'h0000_BEEF, 2'b00, 32'h0,        4'b1100, 32'hBEEF_0000, 2, 32'h0,        0);

        // Reset in the middle of a bus access abandons it without a response.
        wait_ready();
        req_valid   = 1'b1;
        req_store   = 1'b0;
        MemDataType = 3'b010;
        req_addr    = 32'h0000_0080;
        @(posedge CPU_clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge CPU_clk);
        chk("pre_rst_mem_req", {31'b0, mem_req}, 32'd1);
        #2 CPU_rst = 1'b1;
        #1;
        chk("mid_rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("mid_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("mid_rst_req_ready", {31'b0, req_ready}, 32'd1);
        repeat (2) @(negedge CPU_clk);
        CPU_rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CPU_clk);
            if (i == 3) begin
                mem_ack = 1'b1;
                mem_rdata = 32'h5555_5555;
            end else begin
                mem_ack = 1'b0;
            end
            chk("post_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
            chk("post_rst_mem_req", {31'b0, mem_req}, 32'd0);
        end
        mem_ack = 1'b0;

        issue(1'b0, 3'b000, 32'h0000_0000, 32'h0,         2'b00, 32'h0000_007F, 4'b0001, 32'h0,        1, 32'h0000_007F, 0);

        repeat (3) @(negedge CPU_clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Multi-cycle load/store initiator between the RV32IM datapath and a word-organised data memory or bus slave.
- Accepts one load or store request per transaction using the MemDataType funct3 encoding.
- Stores: builds the word-aligned address, byte-lane enables and lane-shifted write data.
- Loads: extracts and sign- or zero-extends the addressed byte or halfword from the returned word.
- Detects illegal data types, misalignment and bus timeouts, and reports each as an error response.

Parameters:
WIDTH, 32, data and address width.
TIMEOUT, 16, maximum cycles spent waiting for mem_ack before a bus-timeout error (must be ≥2).

Ports:
CPU_clk  in  1  single clock, rising edge.
CPU_rst  in  1  asynchronous, active-high reset.
req_valid  in  1  CPU request valid.
req_ready  out  1  unit can accept a request.
req_store  in  1  1 = store, 0 = load.
MemDataType  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
req_addr  in  32  byte address.
req_wdata  in  32  store data, LSB-justified.
mem_req  out  1  memory request, held until ack.
mem_we  out  1  write enable.
mem_addr  out  32  word-aligned address {req_addr[31:2],2'b00}.
mem_be  out  4  byte-lane enables.
mem_wdata  out  32  lane-shifted write data.
mem_ack  in  1  memory completion, one-cycle pulse.
mem_rdata  in  32  read word, valid with mem_ack.
resp_valid  out  1  response valid.
resp_ready  in  1  CPU accepts response.
resp_rdata  out  32  extended load data; 0 for stores and errors.
resp_err  out  2  00 ok, 01 misaligned, 10 illegal type, 11 timeout.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; all outputs 0 except req_ready = 1.
  - Timeout counter = 0.
  - An in-flight transaction is abandoned; mem_req drops immediately.
- FSM states: IDLE, BUS, RESP. All outputs are registered or decoded from state only; no combinational path from req_* to mem_*.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch store flag, type, address and data.
  - Legality check. Illegal type: stores with any type other than 000/001/010; loads with 011/110/111.
  - Alignment check: halfword requires addr[0] = 0; word requires addr[1:0] = 00.
  - Error priority: illegal type (10) over misaligned (01).
  - Any error goes straight to RESP with resp_err set, and no mem_req is issued.
  - Otherwise go to BUS and clear the counter.
- BUS:
  - mem_req = 1 and mem_we = store flag; all mem_* outputs are stable until the ack cycle.
  - Byte-lane enables, with off = addr[1:0]:
    - B/BU: mem_be = 0001 << off.
    - H/HU: mem_be = 0011 << off.
    - W: mem_be = 1111.
  - mem_wdata = req_wdata << (8*off) for stores; 0 for loads.
  - On mem_ack:
    - Load: resp_rdata = the selected lane of mem_rdata, sign-extended for B/H and zero-extended for BU/HU.
    - Store: resp_rdata = 0.
    - resp_err = 00; go to RESP; mem_req deasserts on the next edge.
  - The counter increments each BUS cycle without ack. When it reaches TIMEOUT-1 with no ack, set resp_err = 11, resp_rdata = 0, go to RESP.
  - If ack arrives in the same cycle as the timeout, ack wins.
- RESP:
  - resp_valid = 1 and outputs held stable until resp_ready = 1, then IDLE.
  - req_ready = 1 again in the cycle after the handshake.
  - req_ready = 0 throughout BUS and RESP.
- mem_ack outside BUS is ignored and has no side effect.
- Latency:
  - Request accepted at edge T0; mem_req is high in the cycle after T0.
  - An ack in that first BUS cycle gives resp_valid in the following cycle (minimum 2 cycles from accept to response).
  - An error request gives resp_valid in the cycle after accept.
- Throughput: one transaction outstanding; back-to-back requests separated by at least one IDLE cycle.

Test Plan:
- Reset asserted mid-BUS → mem_req = 0, resp_valid = 0 and req_ready = 1 immediately; no response is issued after reset release.
- Store SB, addr 0x0000_0013, wdata 0x0000_00A5 → mem_addr 0x10, mem_be 1000, mem_wdata 0xA500_0000, mem_we = 1; ack → resp_err 00.
- Load LH addr 0x22 with mem_rdata 0x8001_1234 → mem_be 1100, resp_rdata 0xFFFF_8001. Same access as LHU → 0x0000_8001. LBU addr 0x21 → 0x0000_0012.
- LW addr 0x06 → resp_err 01, no mem_req ever asserted. SB with type 100 → resp_err 10. Type 011 at misaligned addr 0x01 → resp_err 10 (type has priority).
- No mem_ack for TIMEOUT = 16 → resp_err 11 after 16 BUS cycles. Ack in the 16th BUS cycle → resp_err 00 with valid data.
- resp_ready held low for 5 cycles → resp_valid and resp_rdata stable; req_valid ignored (req_ready = 0); stray mem_ack ignored; next request accepted after the handshake.
